// File: rtl/Config.sv
// Shared data-bus definitions used by the core, the GEMM accelerator and the
// bus arbiter that lets them share the data-memory port.
package Config;

    typedef struct packed {
        logic        en;
        logic        rdwr;     // 1 = write, 0 = read
        logic [3:0]  mask;
        logic [31:0] wr_data;
        logic [31:0] addr;
        logic [31:0] rd_data;
    } dbus_interface;

    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_ACC} dbus_gnt_t;

    parameter int DBUS_MAX_LOCK = 16;

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational two-way picker: req[0] is the CPU, req[1] the accelerator.
// last = 1 means the accelerator held the most recent grant.
module dbus_rr_pick
    import Config::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_acc,
    output dbus_gnt_t  gnt
);

    always_comb begin
        gnt = GNT_NONE;
        unique case (req)
            2'b01:   gnt = GNT_CPU;
            2'b10:   gnt = GNT_ACC;
            2'b11:   gnt = (force_acc || !last) ? GNT_ACC : GNT_CPU;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the single data-memory port between the CPU load/store unit and the
// GEMM accelerator: round-robin with a bounded accelerator burst lock.
module dbus_arbiter
    import Config::*;
#(
    parameter int MAX_LOCK = DBUS_MAX_LOCK
) (
    input  logic          clk,
    input  logic          rst,
    input  dbus_interface cpu_req,
    output logic          cpu_stall,
    output logic          cpu_rd_valid,
    output logic [31:0]   cpu_rd_data,
    input  dbus_interface acc_req,
    input  logic          acc_lock,
    output logic          acc_stall,
    output logic          acc_rd_valid,
    output logic [31:0]   acc_rd_data,
    output dbus_interface mem_req,
    input  logic [31:0]   mem_rd_data
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    logic             last_acc;
    logic             lock_active;
    logic [CNT_W-1:0] lock_cnt;
    dbus_gnt_t        rsp_id;
    dbus_gnt_t        gnt;
    logic             cpu_gnt;
    logic             acc_gnt;
    logic             force_acc;
    logic             unused_rd_fields;

    // Requesters never drive meaningful rd_data on their request bundles.
    assign unused_rd_fields = ^{cpu_req.rd_data, acc_req.rd_data};

    assign force_acc = lock_active && (lock_cnt < LOCK_LIMIT);

    dbus_rr_pick u_pick (
        .req       ({acc_req.en, cpu_req.en}),
        .last      (last_acc),
        .force_acc (force_acc),
        .gnt       (gnt)
    );

    assign cpu_gnt   = (gnt == GNT_CPU);
    assign acc_gnt   = (gnt == GNT_ACC);
    assign cpu_stall = cpu_req.en && !cpu_gnt;
    assign acc_stall = acc_req.en && !acc_gnt;

    always_comb begin
        mem_req = '0;
        if (cpu_gnt) begin
            mem_req = cpu_req;
        end else if (acc_gnt) begin
            mem_req = acc_req;
        end
        mem_req.rd_data = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_acc    <= 1'b1;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            rsp_id      <= GNT_NONE;
        end else begin
            if (gnt != GNT_NONE) begin
                last_acc <= acc_gnt;
            end

            // A lock survives only while the accelerator keeps winning with acc_lock high.
            lock_active <= acc_gnt && acc_lock;
            if (cpu_gnt || !(acc_gnt && acc_lock)) begin
                lock_cnt <= '0;
            end else if (cpu_req.en && (lock_cnt != LOCK_LIMIT)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end

            if (cpu_gnt && !cpu_req.rdwr) begin
                rsp_id <= GNT_CPU;
            end else if (acc_gnt && !acc_req.rdwr) begin
                rsp_id <= GNT_ACC;
            end else begin
                rsp_id <= GNT_NONE;
            end
        end
    end

    assign cpu_rd_valid = (rsp_id == GNT_CPU);
    assign acc_rd_valid = (rsp_id == GNT_ACC);
    assign cpu_rd_data  = cpu_rd_valid ? mem_rd_data : '0;
    assign acc_rd_data  = acc_rd_valid ? mem_rd_data : '0;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-requester arbiter that shares the single data-memory port between the RISC-V core's load/store unit and the GEMM accelerator's operand/result mover. Both sides speak `Config::dbus_interface`. Requests are granted combinationally, with round-robin fairness and an accelerator burst lock bounded by a starvation limit. Read data returns one cycle later and is routed back to whichever requester issued the read.

## Interface
- `MAX_LOCK`, default 16: maximum consecutive accelerator grants under `acc_lock` while the CPU is waiting.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in `dbus_interface`: CPU request. Fields used: `en`, `rdwr` (1 = write, 0 = read), `mask`, `wr_data`, `addr`. `rd_data` is ignored.
- `cpu_stall` out 1: CPU request present but not granted this cycle.
- `cpu_rd_valid` out 1: `cpu_rd_data` is valid.
- `cpu_rd_data` out 32: read data returned to the CPU.
- `acc_req` in `dbus_interface`: accelerator request, same field usage as `cpu_req`.
- `acc_lock` in 1: accelerator asks to keep the bus after its current grant.
- `acc_stall` out 1: accelerator request present but not granted this cycle.
- `acc_rd_valid` out 1: `acc_rd_data` is valid.
- `acc_rd_data` out 32: read data returned to the accelerator.
- `mem_req` out `dbus_interface`: request forwarded to memory. Its `rd_data` field is driven 0.
- `mem_rd_data` in 32: memory read data, valid the cycle after a read is issued.

## Operation
- **Grant selection (combinational):**
  - Only one requester has `en=1`: it is granted.
  - Neither requester has `en=1`: no grant, and `mem_req.en=0` with all other `mem_req` fields 0.
  - Both have `en=1`: the winner follows the priority rules below.
- **Priority state:** `last_gnt` (CPU/ACC), updated only on cycles where a grant is made.
  - Round-robin: the requester not in `last_gnt` wins.
  - Lock override: if `lock_active` is set and `lock_cnt < MAX_LOCK`, ACC wins regardless of `last_gnt`.
- **Lock tracking:**
  - `lock_active` is set at the end of any cycle where ACC is granted with `acc_lock=1`.
  - `lock_active` clears when ACC is not granted, or when ACC is granted with `acc_lock=0`.
  - `lock_cnt` increments, saturating at `MAX_LOCK`, on each ACC grant made while `cpu_req.en=1`.
  - `lock_cnt` resets to 0 on any CPU grant, or when `lock_active` clears.
  - Reaching `MAX_LOCK` forces exactly one CPU grant if the CPU is requesting; round-robin then resumes.
- **Forwarding:** `mem_req` equals the granted requester's request, except `rd_data` = 0.
- **Stalls:** `x_stall = x_req.en & ~x_granted`. A stalled requester holds its request stable until it is granted; the arbiter does not check this.
- **Read return:**
  - The arbiter registers `rsp_id` (NONE/CPU/ACC), set on a granted read (`rdwr=0`) and NONE otherwise.
  - Next cycle, the matching `x_rd_valid` = 1 and `x_rd_data = mem_rd_data`.
  - The non-matching `rd_data` is 0.
- **Writes:** complete in the grant cycle and produce no response.

## Timing
- **Reset values:** `last_gnt` = ACC (so the CPU wins the first conflict), `lock_active` = 0, `lock_cnt` = 0, `rsp_id` = NONE.
- **Outputs during reset:** all `rd_valid` = 0, all `rd_data` = 0, `mem_req` = 0 unless a request is present. The stalls remain combinational.
- **Latency:**
  - Request to memory: 0 cycles.
  - Read data to requester: 1 cycle after grant.
  - Back-to-back reads from either side give full throughput, one per cycle.
- **Simultaneous events:**
  - A read grant in cycle N and a grant to the other requester in cycle N+1 are legal. The responses route independently through `rsp_id`.
  - If `acc_lock` deasserts in the same cycle the ACC grant is made, no lock is taken.
- **Reset mid-operation:** asserting `rst` drops any in-flight read response (no `rd_valid` the following cycle). The requester must reissue the read.
- **No-CPU case:** with `cpu_req.en=0`, `lock_cnt` never advances, so ACC is never forced off.

## Structure
- Add to `Config`:
  - `typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_ACC} dbus_gnt_t`
  - `parameter int DBUS_MAX_LOCK = 16`
  - The top-level `MAX_LOCK` defaults to `DBUS_MAX_LOCK`.
- Sub-module `dbus_rr_pick`: a combinational two-way picker (inputs `req[1:0]`, `last`, `force_acc`; output `dbus_gnt_t`).
- The priority state, lock counter and `rsp_id` register stay in `dbus_arbiter`.

## Test plan
- **Single requester:** CPU read of `addr 0x40` alone.
  - Expect `mem_req.addr=0x40`, `cpu_stall=0`.
  - Next cycle, memory returns `0xDEADBEEF`: expect `cpu_rd_valid=1`, `cpu_rd_data=0xDEADBEEF`, `acc_rd_valid=0`.
- **Round-robin conflict:** both request continuously from reset with `acc_lock=0`.
  - Expect grants CPU, ACC, CPU, ACC.
  - Each loser's stall = 1 in alternate cycles.
- **Lock bound:** ACC grabs the bus with `acc_lock=1` held; CPU starts requesting while ACC holds it. Run with `MAX_LOCK=4`.
  - Expect ACC granted for 4 cycles with `cpu_stall=1`, then 1 CPU grant, then ACC again.
- **Interleaved read routing:** CPU read in cycle N, ACC read in cycle N+1.
  - Expect `cpu_rd_valid` at N+1 with the N data.
  - Expect `acc_rd_valid` at N+2 with the N+1 data. The two must never be high together.
- **Write behaviour:** ACC write with `mask=4'b0011`, `wr_data=0x12345678`.
  - Expect `mem_req.rdwr=1`, `mask=0011`, `wr_data=0x12345678`.
  - Expect no `rd_valid` the next cycle.
- **Reset mid-read:** assert `rst` in the cycle after a granted CPU read.
  - Expect `cpu_rd_valid=0`, `rsp_id` = NONE, and `last_gnt` = ACC after release.
